// File: rtl/rd_ptr_empty_pkg.sv
// Shared FIFO pointer helpers: default address width, pointer type, Gray/binary conversion.
package rd_ptr_empty_pkg;

  localparam int unsigned ADD_SIZE_DEF = 8;
  localparam int unsigned PTR_W_DEF    = ADD_SIZE_DEF + 1;

  typedef logic [PTR_W_DEF-1:0] ptr_t;

  // Conversions operate on a 32-bit container; callers size-cast to their pointer width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/rd_ptr_empty_sync.sv
// Two-flop synchronizer bringing the write-domain Gray pointer into rd_clk.
module gray_sync2 #(
  parameter int unsigned WIDTH = 9
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] wq1_q;
  logic [WIDTH-1:0] wq2_q;

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      wq1_q <= '0;
      wq2_q <= '0;
    end else begin
      wq1_q <= async_i;
      wq2_q <= wq1_q;
    end
  end

  assign sync_o = wq2_q;

endmodule

// File: rtl/rd_ptr_empty.sv
// Read-side pointer and empty-flag logic of an async FIFO.
// Optional registered fill level output enabled by defining RD_LEVEL_EN.
module rd_ptr_empty
  import rd_ptr_empty_pkg::*;
#(
  parameter int unsigned add_size = ADD_SIZE_DEF
) (
  input  logic                rd_clk,
  input  logic                rd_rst,
  input  logic                rd_en,
  input  logic [add_size:0]   wr_ptr_gray,
  output logic [add_size:0]   rd_ptr_gray,
  output logic [add_size-1:0] rd_addr,
  output logic                rd_empty,
  output logic                rd_valid,
`ifdef RD_LEVEL_EN
  output logic [add_size:0]   rd_level,
`endif
  output logic                rd_underflow
);

  localparam int unsigned PW = add_size + 1;

  logic [PW-1:0] wq2;
  logic [PW-1:0] rd_bin_q,  rd_bin_d;
  logic [PW-1:0] rd_gray_q, rd_gray_d;
  logic          rd_empty_q, rd_empty_d;
  logic          rd_valid_q, rd_valid_d;
  logic          rd_uflow_q, rd_uflow_d;
  logic          rd_accept;
`ifdef RD_LEVEL_EN
  logic [PW-1:0] rd_level_q, rd_level_d;
`endif

  gray_sync2 #(.WIDTH(PW)) u_wsync (
    .rd_clk  (rd_clk),
    .rd_rst  (rd_rst),
    .async_i (wr_ptr_gray),
    .sync_o  (wq2)
  );

  // Empty compare uses the post-read pointer so the emptying read flags on the same edge.
  always_comb begin
    rd_accept  = rd_en & ~rd_empty_q;
    rd_bin_d   = rd_bin_q + PW'(rd_accept);
    rd_gray_d  = PW'(bin2gray(32'(rd_bin_d)));
    rd_empty_d = (rd_gray_d == wq2);
    rd_valid_d = rd_accept;
    rd_uflow_d = rd_en & rd_empty_q;
`ifdef RD_LEVEL_EN
    rd_level_d = PW'(gray2bin(32'(wq2))) - rd_bin_d;
`endif
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      rd_bin_q   <= '0;
      rd_gray_q  <= '0;
      rd_empty_q <= 1'b1;
      rd_valid_q <= 1'b0;
      rd_uflow_q <= 1'b0;
`ifdef RD_LEVEL_EN
      rd_level_q <= '0;
`endif
    end else begin
      rd_bin_q   <= rd_bin_d;
      rd_gray_q  <= rd_gray_d;
      rd_empty_q <= rd_empty_d;
      rd_valid_q <= rd_valid_d;
      rd_uflow_q <= rd_uflow_d;
`ifdef RD_LEVEL_EN
      rd_level_q <= rd_level_d;
`endif
    end
  end

  assign rd_ptr_gray  = rd_gray_q;
  assign rd_addr      = rd_bin_q[add_size-1:0];
  assign rd_empty     = rd_empty_q;
  assign rd_valid     = rd_valid_q;
  assign rd_underflow = rd_uflow_q;
`ifdef RD_LEVEL_EN
  assign rd_level     = rd_level_q;
`endif

endmodule

// File: tb/tb_rd_ptr_empty.sv
// Directed bench for rd_ptr_empty (add_size=8); level checks compiled in with RD_LEVEL_EN.
module tb_rd_ptr_empty;

  localparam int unsigned AS = 8;
  localparam int unsigned PW = AS + 1;

  logic          rd_clk = 1'b0;
  logic          rd_rst;
  logic          rd_en;
  logic [PW-1:0] wr_ptr_gray;
  logic [PW-1:0] rd_ptr_gray;
  logic [AS-1:0] rd_addr;
  logic          rd_empty;
  logic          rd_valid;
  logic          rd_underflow;
`ifdef RD_LEVEL_EN
  logic [PW-1:0] rd_level;
`endif

  int vectors     = 0;
  int miscompares = 0;

  rd_ptr_empty #(.add_size(AS)) dut (
    .rd_clk       (rd_clk),
    .rd_rst       (rd_rst),
    .rd_en        (rd_en),
    .wr_ptr_gray  (wr_ptr_gray),
    .rd_ptr_gray  (rd_ptr_gray),
    .rd_addr      (rd_addr),
    .rd_empty     (rd_empty),
    .rd_valid     (rd_valid),
`ifdef RD_LEVEL_EN
    .rd_level     (rd_level),
`endif
    .rd_underflow (rd_underflow)
  );

  always #5 rd_clk = ~rd_clk;

  function automatic logic [PW-1:0] gray(input int unsigned b);
    logic [PW-1:0] v;
    v = PW'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_empty"}, 32'(rd_empty), 32'd1);
    chk({tag, "_gray"}, 32'(rd_ptr_gray), 32'h000);
    chk({tag, "_addr"}, 32'(rd_addr), 32'h00);
    chk({tag, "_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, "_uflow"}, 32'(rd_underflow), 32'd0);
`ifdef RD_LEVEL_EN
    chk({tag, "_level"}, 32'(rd_level), 32'd0);
`endif
  endtask

  int unsigned   wb;
  logic [PW-1:0] prev_gray;

  initial begin
    // Reset for two cycles with rd_en asserted: reset must win.
    rd_rst = 1'b1; rd_en = 1'b1; wr_ptr_gray = '0;
    tick(); tick();
    chk_reset_state("reset");
    rd_rst = 1'b0; rd_en = 1'b0;

    // Write pointer step 0 -> 1: empty clears on the third edge.
    wr_ptr_gray = gray(1);
    tick(); chk("wstep_e1", 32'(rd_empty), 32'd1);
    tick(); chk("wstep_e2", 32'(rd_empty), 32'd1);
    tick(); chk("wstep_e3", 32'(rd_empty), 32'd0);

    // Single read held into the next cycle: one accept, then underflow.
    rd_en = 1'b1;
    tick();
    chk("rd1_valid", 32'(rd_valid), 32'd1);
    chk("rd1_addr", 32'(rd_addr), 32'h01);
    chk("rd1_gray", 32'(rd_ptr_gray), 32'h001);
    chk("rd1_empty", 32'(rd_empty), 32'd1);
    tick();
    chk("hold_uflow", 32'(rd_underflow), 32'd1);
    chk("hold_valid", 32'(rd_valid), 32'd0);
    chk("hold_gray", 32'(rd_ptr_gray), 32'h001);
    rd_en = 1'b0;
    tick();
    chk("hold_uflow_end", 32'(rd_underflow), 32'd0);

    // Isolated underflow request produces exactly one pulse.
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("uf_pulse", 32'(rd_underflow), 32'd1);
    chk("uf_valid", 32'(rd_valid), 32'd0);
    chk("uf_gray", 32'(rd_ptr_gray), 32'h001);
    tick();
    chk("uf_single", 32'(rd_underflow), 32'd0);

    // Reset in the middle of a read burst.
    wr_ptr_gray = gray(6);
    tick(); tick(); tick();
    chk("burst_ready", 32'(rd_empty), 32'd0);
    rd_en = 1'b1;
    tick(); chk("burst_v1", 32'(rd_valid), 32'd1); chk("burst_a1", 32'(rd_addr), 32'h02);
    tick(); chk("burst_v2", 32'(rd_valid), 32'd1); chk("burst_a2", 32'(rd_addr), 32'h03);
    rd_rst = 1'b1; wr_ptr_gray = '0;
    tick();
    chk_reset_state("midrst");
    rd_rst = 1'b0; rd_en = 1'b0;
    tick();
    chk("midrst_novalid", 32'(rd_valid), 32'd0);
    chk("midrst_empty", 32'(rd_empty), 32'd1);

    // 512 write/read pairs walk the pointer through the full wrap.
    wb = 0;
    prev_gray = '0;
    for (int i = 0; i < 512; i++) begin
      wb = (wb + 1) % 512;
      wr_ptr_gray = gray(wb);
      tick(); tick(); tick();
      chk("wrap_notempty", 32'(rd_empty), 32'd0);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("wrap_gray", 32'(rd_ptr_gray), 32'(gray(wb)));
      chk("wrap_onebit", $countones(rd_ptr_gray ^ prev_gray), 32'd1);
      chk("wrap_empty", 32'(rd_empty), 32'd1);
      chk("wrap_valid", 32'(rd_valid), 32'd1);
      prev_gray = rd_ptr_gray;
    end
    chk("wrap_end_gray", 32'(rd_ptr_gray), 32'h000);
    chk("wrap_end_addr", 32'(rd_addr), 32'h00);

    // Half-full FIFO, then ten back-to-back reads.
    wr_ptr_gray = gray(256);
    tick(); tick(); tick();
    chk("half_empty", 32'(rd_empty), 32'd0);
`ifdef RD_LEVEL_EN
    chk("level_256", 32'(rd_level), 32'd256);
`endif
    rd_en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("b2b_valid", 32'(rd_valid), 32'd1);
      chk("b2b_addr", 32'(rd_addr), 32'(i));
    end
    rd_en = 1'b0;
    chk("b2b_empty", 32'(rd_empty), 32'd0);
`ifdef RD_LEVEL_EN
    chk("level_246", 32'(rd_level), 32'd246);
`endif
    tick();
    chk("b2b_idle_valid", 32'(rd_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
